ysyx_22050612_mem_arb: RTL and testbench
========================================

// Module: ysyx_22050612_mem_arb
// PURPOSE
//  Two-requester arbiter and sequencer for the single data-memory port (DPI pmem model).
//  Shares the port between the IFU (read-only fetch) and the LSU (load/store, byte-masked write).
//  Sits between the IFU/EXU and the memory model. One transaction outstanding at a time.
// PARAMETERS
//  AW  64  address width
//  DW  64  data width
//  MW  8   write-mask width; must equal DW/8
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst             in   1   synchronous reset, active-high
//  ifu_req_valid   in   1   IFU read request
//  ifu_req_ready   out  1   IFU request accepted this cycle
//  ifu_req_addr    in   AW  fetch address
//  ifu_resp_valid  out  1   one-cycle pulse: fetch data valid
//  ifu_resp_data   out  DW  fetch data
//  lsu_req_valid   in   1   LSU request
//  lsu_req_ready   out  1   LSU request accepted this cycle
//  lsu_req_addr    in   AW  load/store address, passed through unmodified
//  lsu_req_wen     in   1   1 = store, 0 = load
//  lsu_req_wdata   in   DW  store data, already lane-aligned
//  lsu_req_wmask   in   MW  store byte mask
//  lsu_resp_valid  out  1   one-cycle pulse: load data valid / store done
//  lsu_resp_data   out  DW  load data; 0 for stores
//  mem_req_valid   out  1   request to memory
//  mem_req_ready   in   1   memory accepts request
//  mem_req_addr    out  AW  latched address
//  mem_req_wen     out  1   latched write enable; 0 for IFU
//  mem_req_wdata   out  DW  latched data; 0 for IFU
//  mem_req_wmask   out  MW  latched mask; 0 for IFU and loads
//  mem_resp_valid  in   1   memory response / write ack
//  mem_resp_data   in   DW  memory read data
// BEHAVIOUR
//  FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE: if either req_valid is high, pick a winner; assert its req_ready combinationally
//   in the same cycle; latch addr/wen/wdata/wmask and owner; next state ISSUE.
//  Tie (both valid): the requester that is not last_grant wins. last_grant resets to LSU,
//   so IFU wins the first tie. A lone requester always wins. last_grant updates on accept.
//  ISSUE: mem_req_valid=1 with the latched fields held stable; on mem_req_ready go to WAIT.
//  WAIT: on mem_resp_valid, pulse the owner's resp_valid combinationally in the same cycle;
//   resp_data = mem_resp_data (LSU store: 0); next state IDLE.
//  A new request is accepted one cycle after a response at the earliest, never in WAIT.
//  Minimum latency accept->resp = 2 cycles (ready in ISSUE, resp the next cycle).
//  mem_resp_valid in IDLE or ISSUE is ignored (no pulse, no state change).
//  req_ready is 0 in ISSUE and WAIT; the non-winning requester holds its request.
//  Reset values: state=IDLE, last_grant=LSU; all req_ready/resp_valid/mem_req_valid=0;
//   latched fields=0.
//  Reset mid-transaction: abandon it and go to IDLE; no response pulse; a late
//   mem_resp_valid after reset is ignored.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: add outputs perf_ifu_grant[31:0], perf_lsu_grant[31:0],
//   and perf_conflict[31:0] (cycles in IDLE with both valid, plus cycles with any
//   req_valid high while not IDLE). Counters reset to 0, wrap 0xFFFFFFFF->0, +1 per event.
//  Not defined: these ports and counters are absent. Functional behaviour is identical.
// STRUCTURE
//  ysyx_22050612_mem_pkg: state enum {IDLE,ISSUE,WAIT}, owner enum {OWN_IFU,OWN_LSU}, AW/DW/MW.
//  Sub-module ysyx_22050612_rr_arb2: combinational 2-way round-robin pick;
//   inputs are the two valids and last_grant, outputs are the one-hot grant.
//  The top level holds the FSM, request latches, response steering and optional counters.
// TESTING
//  1 IFU-only: addr=0x80000000; mem ready in ISSUE, resp 0x1234 in the next cycle
//    -> ifu_resp_valid one pulse, data 0x1234; 2 cycles accept->resp.
//  2 Tie after reset: both valid -> IFU granted first, LSU second; then another tie
//    -> IFU again (last=LSU); alternates on every subsequent tie.
//  3 LSU store: addr=0x80000008, wdata=0xAB<<8, wmask=0x02, mem_req_ready delayed 3 cycles
//    -> mem fields stable throughout; lsu_resp_data=0.
//  4 Spurious mem_resp_valid in IDLE and in ISSUE -> no resp pulse, state unchanged.
//  5 rst asserted in WAIT -> IDLE next cycle; a later resp gives no pulse; next request
//    is served normally.
//  6 ARB_PERF_CNT_EN: 10 ties -> grants 5/5, perf_conflict>=10; preload counter near wrap
//    -> wraps to 0.

Source files
------------

// File: rtl/ysyx_22050612_mem_arb_pkg.sv
// ysyx_22050612_mem_pkg
//   Shared types and sizes for the data-memory arbiter slice.
//   AW/DW/MW : address, data and byte-mask widths (MW == DW/8).
//   state_e  : sequencer states; ST_* are the encoded constants used by the FSM.
//   owner_e  : which requester owns the outstanding transaction.
package ysyx_22050612_mem_pkg;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;

endpackage

// File: rtl/ysyx_22050612_mem_arb_if.sv
// ysyx_22050612_mem_arb_if
//   Request/response bundle used for the IFU, the LSU and the memory port.
//   master : drives req_valid/addr/wen/wdata/wmask, receives req_ready/resp_*.
//   slave  : the opposite direction.
//   The IFU never writes; its wen/wdata/wmask are tied off by whoever drives it.
interface ysyx_22050612_mem_arb_if
  import ysyx_22050612_mem_pkg::*;
  ();

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_wen;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          resp_valid;
  logic [DW-1:0] resp_data;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/ysyx_22050612_mem_arb_rr_arb2.sv
// ysyx_22050612_rr_arb2
//   Combinational two-way round-robin pick.
//   ifu_valid, lsu_valid : request lines
//   last_grant           : owner of the most recent accepted request
//   grant[0]=IFU, grant[1]=LSU : one-hot (or zero) winner
//   A lone requester always wins; on a tie the one not granted last wins.
module ysyx_22050612_rr_arb2
  import ysyx_22050612_mem_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = ifu_valid && (!lsu_valid || (last_grant == OWN_LSU));
    grant[1] = lsu_valid && !grant[0];
  end

endmodule

// File: rtl/ysyx_22050612_mem_arb.sv
// ysyx_22050612_mem_arb
//   Shares the single data-memory port between IFU fetches and LSU
//   loads/stores, one transaction outstanding at a time.
//   clk, rst : clock and synchronous active-high reset
//   ifu      : slave bundle, read-only fetch requests
//   lsu      : slave bundle, loads and byte-masked stores
//   mem      : master bundle towards the memory model
//   Optional (macro ARB_PERF_CNT_EN): perf_ifu_grant, perf_lsu_grant,
//   perf_conflict 32-bit wrapping event counters.
//
//   state | meaning
//   IDLE  | no transaction; accept the arbitration winner
//   ISSUE | mem_req_valid high with latched fields, waiting for mem_req_ready
//   WAIT  | request taken, waiting for mem_resp_valid to steer to the owner
module ysyx_22050612_mem_arb
  import ysyx_22050612_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22050612_mem_arb_if.slave   ifu,
  ysyx_22050612_mem_arb_if.slave   lsu,
  ysyx_22050612_mem_arb_if.master  mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]              perf_ifu_grant,
  output logic [31:0]              perf_lsu_grant,
  output logic [31:0]              perf_conflict
`endif
);

  logic [1:0]    state_q;
  owner_e        last_grant_q;
  owner_e        owner_q;
  logic [AW-1:0] addr_q;
  logic          wen_q;
  logic [DW-1:0] wdata_q;
  logic [MW-1:0] wmask_q;

  logic [1:0]    grant;
  logic          in_idle;
  logic          accept;
  logic          resp_fire;

  ysyx_22050612_rr_arb2 u_rr_arb2 (
    .ifu_valid  (ifu.req_valid),
    .lsu_valid  (lsu.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Gating with rst keeps a reset cycle from handshaking a request or
  // delivering a response that the reset is about to throw away.
  assign in_idle   = (state_q == ST_IDLE) && !rst;
  assign accept    = in_idle && (grant != 2'b00);
  assign resp_fire = (state_q == ST_WAIT) && mem.resp_valid && !rst;

  assign ifu.req_ready = in_idle && grant[0];
  assign lsu.req_ready = in_idle && grant[1];

  assign mem.req_valid = (state_q == ST_ISSUE);
  assign mem.req_addr  = addr_q;
  assign mem.req_wen   = wen_q;
  assign mem.req_wdata = wdata_q;
  assign mem.req_wmask = wmask_q;

  assign ifu.resp_valid = resp_fire && (owner_q == OWN_IFU);
  assign ifu.resp_data  = ifu.resp_valid ? mem.resp_data : '0;
  assign lsu.resp_valid = resp_fire && (owner_q == OWN_LSU);
  // Store acknowledgements carry no data.
  assign lsu.resp_data  = (lsu.resp_valid && !wen_q) ? mem.resp_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_LSU;
      owner_q      <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_ISSUE;
            if (grant[1]) begin
              owner_q      <= OWN_LSU;
              last_grant_q <= OWN_LSU;
              addr_q       <= lsu.req_addr;
              wen_q        <= lsu.req_wen;
              wdata_q      <= lsu.req_wdata;
              wmask_q      <= lsu.req_wen ? lsu.req_wmask : '0;
            end else begin
              owner_q      <= OWN_IFU;
              last_grant_q <= OWN_IFU;
              addr_q       <= ifu.req_addr;
              wen_q        <= 1'b0;
              wdata_q      <= '0;
              wmask_q      <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (mem.req_ready) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem.resp_valid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic conflict_evt;

  // A conflict is a cycle where some requester is left waiting: both asking
  // in IDLE, or anyone asking while a transaction is in flight.
  assign conflict_evt = (state_q == ST_IDLE) ? (ifu.req_valid && lsu.req_valid)
                                             : (ifu.req_valid || lsu.req_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ifu_grant <= '0;
      perf_lsu_grant <= '0;
      perf_conflict  <= '0;
    end else begin
      if (ifu.req_ready) perf_ifu_grant <= perf_ifu_grant + 32'd1;
      if (lsu.req_ready) perf_lsu_grant <= perf_lsu_grant + 32'd1;
      if (conflict_evt)  perf_conflict  <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050612_mem_arb.sv
module tb_ysyx_22050612_mem_arb;
  import ysyx_22050612_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22050612_mem_arb_if ifu_bus ();
  ysyx_22050612_mem_arb_if lsu_bus ();
  ysyx_22050612_mem_arb_if mem_bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] pig, plg, pcf;
`endif

  ysyx_22050612_mem_arb dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_bus),
    .lsu (lsu_bus),
    .mem (mem_bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_ifu_grant (pig),
    .perf_lsu_grant (plg),
    .perf_conflict  (pcf)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level model: is a transaction outstanding, has memory taken it,
  // who owns it, who was granted last, and what fields were captured.
  bit          m_out, m_iss, m_own, m_last; // owner: 0=IFU 1=LSU
  logic [63:0] m_addr, m_wdata;
  logic        m_wen;
  logic [7:0]  m_wmask;

  // Observations from the most recent cycle, for directed literal checks.
  bit          o_ifu_acc, o_lsu_acc, o_ifu_resp, o_lsu_resp, o_mem_valid;
  logic [63:0] o_ifu_data, o_lsu_data, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        o_mem_wen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_iss = 0; m_own = 0; m_last = 1;
    m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0;
  endtask

  // Inputs are set at a negedge; sample just after, compare, advance the model.
  task automatic cycle();
    bit iv, lv, w_ifu, w_lsu, resp;
    #1;
    o_ifu_acc   = ifu_bus.req_ready;  o_lsu_acc  = lsu_bus.req_ready;
    o_ifu_resp  = ifu_bus.resp_valid; o_lsu_resp = lsu_bus.resp_valid;
    o_ifu_data  = ifu_bus.resp_data;  o_lsu_data = lsu_bus.resp_data;
    o_mem_valid = mem_bus.req_valid;  o_mem_addr = mem_bus.req_addr;
    o_mem_wdata = mem_bus.req_wdata;  o_mem_wmask = mem_bus.req_wmask;
    o_mem_wen   = mem_bus.req_wen;
    if (rst) begin
      model_reset();
      o_ifu_acc = 0; o_lsu_acc = 0;
    end else begin
      iv = ifu_bus.req_valid; lv = lsu_bus.req_valid;
      w_ifu = !m_out && iv && (!lv || m_last == 1);
      w_lsu = !m_out && lv && !w_ifu;
      resp  = m_out && m_iss && mem_bus.resp_valid;
      chk("ifu_req_ready", ifu_bus.req_ready, w_ifu);
      chk("lsu_req_ready", lsu_bus.req_ready, w_lsu);
      chk("mem_req_valid", mem_bus.req_valid, m_out && !m_iss);
      chk("mem_req_addr",  mem_bus.req_addr, m_addr);
      chk("mem_req_wen",   mem_bus.req_wen, m_wen);
      chk("mem_req_wdata", mem_bus.req_wdata, m_wdata);
      chk("mem_req_wmask", mem_bus.req_wmask, m_wmask);
      chk("ifu_resp_valid", ifu_bus.resp_valid, resp && m_own == 0);
      chk("lsu_resp_valid", lsu_bus.resp_valid, resp && m_own == 1);
      if (resp && m_own == 0) chk("ifu_resp_data", ifu_bus.resp_data, mem_bus.resp_data);
      if (resp && m_own == 1)
        chk("lsu_resp_data", lsu_bus.resp_data, m_wen ? 64'h0 : mem_bus.resp_data);
      if (resp) m_out = 0;
      else if (m_out && !m_iss && mem_bus.req_ready) m_iss = 1;
      if (w_ifu) begin
        m_out = 1; m_iss = 0; m_own = 0; m_last = 0;
        m_addr = ifu_bus.req_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
      end
      if (w_lsu) begin
        m_out = 1; m_iss = 0; m_own = 1; m_last = 1;
        m_addr = lsu_bus.req_addr; m_wen = lsu_bus.req_wen;
        m_wdata = lsu_bus.req_wdata;
        m_wmask = lsu_bus.req_wen ? lsu_bus.req_wmask : 8'h0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_bus.req_valid = 0; ifu_bus.req_addr = '0;
    ifu_bus.req_wen = 0; ifu_bus.req_wdata = '0; ifu_bus.req_wmask = '0;
    lsu_bus.req_valid = 0; lsu_bus.req_addr = '0;
    lsu_bus.req_wen = 0; lsu_bus.req_wdata = '0; lsu_bus.req_wmask = '0;
    mem_bus.req_ready = 0; mem_bus.resp_valid = 0; mem_bus.resp_data = '0;
  endtask

  task automatic do_reset();
    rst = 1; cycle(); cycle(); rst = 0;
  endtask

  bit grants[$];

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // reset state
    chk("reset_mem_valid", mem_bus.req_valid, 0);
    chk("reset_mem_addr", mem_bus.req_addr, 0);

    // IFU-only fetch, 2 cycles accept->resp
    ifu_bus.req_valid = 1; ifu_bus.req_addr = 64'h8000_0000;
    cycle();
    chk("t1_accept", o_ifu_acc, 1);
    ifu_bus.req_valid = 0; mem_bus.req_ready = 1;
    cycle();
    chk("t1_issue_valid", o_mem_valid, 1);
    chk("t1_issue_addr", o_mem_addr, 64'h8000_0000);
    mem_bus.req_ready = 0; mem_bus.resp_valid = 1; mem_bus.resp_data = 64'h1234;
    cycle();
    chk("t1_resp_valid", o_ifu_resp, 1);
    chk("t1_resp_data", o_ifu_data, 64'h1234);
    mem_bus.resp_valid = 0;
    cycle();
    chk("t1_single_pulse", o_ifu_resp, 0);

    // ties after reset alternate IFU, LSU, IFU, LSU
    do_reset();
    ifu_bus.req_valid = 1; ifu_bus.req_addr = 64'h8000_0100;
    lsu_bus.req_valid = 1; lsu_bus.req_addr = 64'h8000_0200;
    lsu_bus.req_wdata = 64'h55; lsu_bus.req_wmask = 8'hFF;
    mem_bus.req_ready = 1; mem_bus.resp_valid = 1; mem_bus.resp_data = 64'hCAFE;
    grants.delete();
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (o_ifu_acc) grants.push_back(1'b0);
      if (o_lsu_acc) grants.push_back(1'b1);
    end
    chk("t2_grant_count", grants.size(), 4);
    if (grants.size() >= 4) begin
      chk("t2_tie0_ifu", grants[0], 0);
      chk("t2_tie1_lsu", grants[1], 1);
      chk("t2_tie2_ifu", grants[2], 0);
      chk("t2_tie3_lsu", grants[3], 1);
    end

    // LSU store with mem_req_ready held off for 3 cycles
    idle_inputs();
    cycle(); cycle();
    lsu_bus.req_valid = 1; lsu_bus.req_addr = 64'h8000_0008; lsu_bus.req_wen = 1;
    lsu_bus.req_wdata = 64'hAB << 8; lsu_bus.req_wmask = 8'h02;
    cycle();
    chk("t3_accept", o_lsu_acc, 1);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      mem_bus.req_ready = (i == 3);
      cycle();
      chk("t3_valid", o_mem_valid, 1);
      chk("t3_addr", o_mem_addr, 64'h8000_0008);
      chk("t3_wdata", o_mem_wdata, 64'hAB00);
      chk("t3_wmask", o_mem_wmask, 8'h02);
      chk("t3_wen", o_mem_wen, 1);
    end
    mem_bus.req_ready = 0; mem_bus.resp_valid = 1; mem_bus.resp_data = 64'hDEAD_BEEF;
    cycle();
    chk("t3_resp_valid", o_lsu_resp, 1);
    chk("t3_resp_data", o_lsu_data, 0);

    // spurious responses in IDLE and ISSUE
    idle_inputs();
    mem_bus.resp_valid = 1;
    cycle();
    chk("t4_idle_no_pulse", o_ifu_resp | o_lsu_resp, 0);
    ifu_bus.req_valid = 1; ifu_bus.req_addr = 64'h8000_0040;
    cycle();
    chk("t4_accept", o_ifu_acc, 1);
    ifu_bus.req_valid = 0;
    cycle();
    chk("t4_issue_no_pulse", o_ifu_resp | o_lsu_resp, 0);
    cycle();
    chk("t4_still_issue", o_mem_valid, 1);
    mem_bus.resp_valid = 0; mem_bus.req_ready = 1;
    cycle();
    mem_bus.req_ready = 0; mem_bus.resp_valid = 1; mem_bus.resp_data = 64'h77;
    cycle();
    chk("t4_resp", o_ifu_resp, 1);

    // reset while in WAIT
    idle_inputs();
    ifu_bus.req_valid = 1; ifu_bus.req_addr = 64'h8000_0080;
    cycle();
    ifu_bus.req_valid = 0; mem_bus.req_ready = 1;
    cycle();
    mem_bus.req_ready = 0; rst = 1;
    cycle();
    rst = 0; mem_bus.resp_valid = 1; mem_bus.resp_data = 64'h99;
    cycle();
    chk("t5_late_no_pulse", o_ifu_resp | o_lsu_resp, 0);
    chk("t5_idle", o_mem_valid, 0);
    mem_bus.resp_valid = 0;
    lsu_bus.req_valid = 1; lsu_bus.req_addr = 64'h8000_00C0;
    cycle();
    chk("t5_accept", o_lsu_acc, 1);
    lsu_bus.req_valid = 0; mem_bus.req_ready = 1;
    cycle();
    mem_bus.req_ready = 0; mem_bus.resp_valid = 1; mem_bus.resp_data = 64'h4242;
    cycle();
    chk("t5_resp", o_lsu_resp, 1);
    chk("t5_resp_data", o_lsu_data, 64'h4242);

`ifdef ARB_PERF_CNT_EN
    idle_inputs();
    do_reset();
    ifu_bus.req_valid = 1; lsu_bus.req_valid = 1;
    mem_bus.req_ready = 1; mem_bus.resp_valid = 1;
    for (int i = 0; i < 30; i++) cycle();
    chk("perf_ifu", pig, 5);
    chk("perf_lsu", plg, 5);
    chk("perf_conflict_min", (pcf >= 10), 1);
`endif

    // randomized traffic
    idle_inputs();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!ifu_bus.req_valid || o_ifu_acc) begin
        ifu_bus.req_valid = ($urandom_range(0, 2) != 0);
        ifu_bus.req_addr  = {32'h0, $urandom} & ~64'h3;
      end
      if (!lsu_bus.req_valid || o_lsu_acc) begin
        lsu_bus.req_valid = ($urandom_range(0, 2) != 0);
        lsu_bus.req_addr  = {$urandom, $urandom};
        lsu_bus.req_wen   = $urandom_range(0, 1);
        lsu_bus.req_wdata = {$urandom, $urandom};
        lsu_bus.req_wmask = 8'($urandom);
      end
      mem_bus.req_ready  = $urandom_range(0, 1);
      mem_bus.resp_valid = $urandom_range(0, 1);
      mem_bus.resp_data  = {$urandom, $urandom};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
